bit_count_scheduler: RTL

//  Round-robin scheduler that shares one bit-counter engine between N requesters.
//  - Accepts one 8-bit word at a time from the winning requester.
//  - Issues the word to the engine over its Valid/Ready handshake and waits for the result.
//  - Returns the result to the originating requester on a per-requester response handshake.
//  - Sits between client blocks and the single counter instance.

---
 rtl/bit_count_scheduler.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/bit_count_scheduler.sv
// Round-robin scheduler sharing one bit-counter engine among N requesters.
// Defining BIT_COUNT_SCHED_TIMEOUT_EN adds a BUSY watchdog that aborts a stuck job.
module bit_count_scheduler #(
    parameter int unsigned N           = 4,
    parameter int unsigned DW          = 8,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    output logic [N-1:0]         req_ready,
    input  logic [N*DW-1:0]      req_data,
    output logic [N-1:0]         rsp_valid,
    input  logic [N-1:0]         rsp_ready,
    output logic [DW-1:0]        rsp_data,
    output logic                 rsp_err,
    output logic                 cnt_valid,
    input  logic                 cnt_ready,
    output logic [DW-1:0]        cnt_data_in,
    input  logic [DW-1:0]        cnt_data_out,
    output logic                 busy,
    output logic [$clog2(N)-1:0] grant_id
);

    localparam int unsigned ID_W = $clog2(N);

    if (N < 2) begin : g_bad_n
        $error("bit_count_scheduler: N must be at least 2");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("bit_count_scheduler: TIMEOUT_CYC must be at least 2");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StBusy, StResp} state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [DW-1:0]   word_q, word_d;
    logic            seen_low_q, seen_low_d;
    logic [N-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;
    logic            cnt_valid_q, cnt_valid_d;
    logic            busy_q, busy_d;

`ifdef BIT_COUNT_SCHED_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC);
    logic [TW-1:0] timer_q, timer_d;
`endif

    logic [DW-1:0] req_word [N];
    for (genvar i = 0; i < N; i++) begin : g_word
        assign req_word[i] = req_data[i*DW +: DW];
    end

    // Rotating priority: search starts one past the last requester served.
    logic            grant_vld;
    logic [ID_W-1:0] grant_idx;
    always_comb begin : p_grant
        logic [ID_W-1:0] cand;
        cand      = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = ID_W'((32'(ptr_q) + k) % N);
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == StIdle && grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        word_d      = word_q;
        seen_low_d  = seen_low_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        cnt_valid_d = cnt_valid_q;
`ifdef BIT_COUNT_SCHED_TIMEOUT_EN
        timer_d     = timer_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (grant_vld) begin
                    word_d      = req_word[grant_idx];
                    id_d        = grant_idx;
                    cnt_valid_d = 1'b1;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (cnt_ready) begin
                    cnt_valid_d = 1'b0;
                    seen_low_d  = 1'b0;
`ifdef BIT_COUNT_SCHED_TIMEOUT_EN
                    timer_d     = '0;
`endif
                    state_d     = StBusy;
                end
            end
            StBusy: begin
                // Ready may still be high the cycle after accept; only a rise after a low counts.
                if (!cnt_ready) begin
                    seen_low_d = 1'b1;
                end
                if (cnt_ready && seen_low_q) begin
                    rsp_data_d      = cnt_data_out;
                    rsp_err_d       = 1'b0;
                    rsp_valid_d     = '0;
                    rsp_valid_d[id_q] = 1'b1;
                    state_d         = StResp;
                end
`ifdef BIT_COUNT_SCHED_TIMEOUT_EN
                else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                    rsp_data_d      = '1;
                    rsp_err_d       = 1'b1;
                    rsp_valid_d     = '0;
                    rsp_valid_d[id_q] = 1'b1;
                    state_d         = StResp;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end
            StResp: begin
                if (rsp_ready[id_q]) begin
                    rsp_valid_d = '0;
                    ptr_d       = id_q;
                    state_d     = StIdle;
                end
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= ID_W'(N - 1);
            id_q        <= '0;
            word_q      <= '0;
            seen_low_q  <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            cnt_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            word_q      <= word_d;
            seen_low_q  <= seen_low_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            cnt_valid_q <= cnt_valid_d;
            busy_q      <= busy_d;
        end
    end

`ifdef BIT_COUNT_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign cnt_valid   = cnt_valid_q;
    assign cnt_data_in = word_q;
    assign busy        = busy_q;
    assign grant_id    = id_q;

endmodule
